// File: rtl/instr_decode.sv
// instr_decode: instruction decode and issue stage feeding GPReg.
//
// Accepts 32-bit words over a valid/ready handshake, splits them into register
// selects, a GPReg command and immediate data, and drives those from registers.
// Opcode 0x4 (LDI long) takes a second word that is used raw as MemData.
//
// Word format: [31:28] opcode, [27:25] SelZ, [24:22] SelX, [21:19] SelY, [18:0] imm.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   instr, instr_valid   incoming word and its valid
//   instr_ready          combinational, equals !stall
//   stall, flush         downstream hold, synchronous drop of in-flight work
//   SelX/SelY/SelZ       register selects
//   MemInstruction       00 NOP, 01 read/op, 10 store, 11 write MemData to SelZ
//   MemData              immediate data
//   issue_valid          outputs carry a new instruction this cycle
//   illegal              sticky illegal-opcode flag
//   illegal_cnt          saturating illegal count, present only when the
//                        INSTR_DECODE_ILLEGAL_CNT_EN macro is defined
module instr_decode #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [2:0]        SelX,
    output logic [2:0]        SelY,
    output logic [2:0]        SelZ,
    output logic [1:0]        MemInstruction,
    output logic [DATA_W-1:0] MemData,
    output logic              issue_valid,
`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
    output logic [7:0]        illegal_cnt,
`endif
    output logic              illegal
);

    typedef enum logic [0:0] {StDecode, StWaitImm} state_e;

    state_e state_q, state_d;

    logic [3:0]        opcode;
    logic              accept;
    logic [2:0]        sel_x_d, sel_y_d, sel_z_d;
    logic [2:0]        pend_x_q, pend_y_q, pend_z_q;
    logic [2:0]        pend_x_d, pend_y_d, pend_z_d;
    logic [1:0]        mem_instr_d;
    logic [DATA_W-1:0] mem_data_d;
    logic              issue_valid_d;
    logic              illegal_d;
    logic              illegal_hit;

    assign instr_ready = !stall;
    assign opcode      = instr[31:28];
    // Flush drops a word presented in the same cycle.
    assign accept      = instr_valid && !stall && !flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StDecode;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StDecode;
        end else if (accept) begin
            unique case (state_q)
                StDecode:  state_d = (opcode == 4'h4) ? StWaitImm : StDecode;
                StWaitImm: state_d = StDecode;
                default:   state_d = StDecode;
            endcase
        end
    end

    // Output next-values: hold by default so stall freezes everything.
    always_comb begin
        sel_x_d       = SelX;
        sel_y_d       = SelY;
        sel_z_d       = SelZ;
        pend_x_d      = pend_x_q;
        pend_y_d      = pend_y_q;
        pend_z_d      = pend_z_q;
        mem_instr_d   = MemInstruction;
        mem_data_d    = MemData;
        issue_valid_d = issue_valid;
        illegal_d     = illegal;
        illegal_hit   = 1'b0;
        if (flush) begin
            issue_valid_d = 1'b0;
            mem_instr_d   = 2'b00;
        end else if (stall) begin
            // hold
        end else if (accept) begin
            if (state_q == StWaitImm) begin
                // Second word of LDI long: raw immediate, never decoded.
                sel_x_d       = pend_x_q;
                sel_y_d       = pend_y_q;
                sel_z_d       = pend_z_q;
                mem_instr_d   = 2'b11;
                mem_data_d    = instr;
                issue_valid_d = 1'b1;
            end else begin
                sel_z_d       = instr[27:25];
                sel_x_d       = instr[24:22];
                sel_y_d       = instr[21:19];
                issue_valid_d = 1'b1;
                case (opcode)
                    4'h0: mem_instr_d = 2'b00;
                    4'h1: mem_instr_d = 2'b01;
                    4'h2: mem_instr_d = 2'b10;
                    4'h3: begin
                        mem_instr_d = 2'b11;
                        mem_data_d  = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
                    end
                    4'h4: begin
                        // Park the selects; visible outputs stay as they were.
                        sel_x_d       = SelX;
                        sel_y_d       = SelY;
                        sel_z_d       = SelZ;
                        pend_z_d      = instr[27:25];
                        pend_x_d      = instr[24:22];
                        pend_y_d      = instr[21:19];
                        mem_instr_d   = 2'b00;
                        issue_valid_d = 1'b0;
                    end
                    default: begin
                        mem_instr_d = 2'b00;
                        illegal_d   = 1'b1;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
        end else begin
            issue_valid_d = 1'b0;
            mem_instr_d   = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SelX           <= '0;
            SelY           <= '0;
            SelZ           <= '0;
            pend_x_q       <= '0;
            pend_y_q       <= '0;
            pend_z_q       <= '0;
            MemInstruction <= 2'b00;
            MemData        <= '0;
            issue_valid    <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            SelX           <= sel_x_d;
            SelY           <= sel_y_d;
            SelZ           <= sel_z_d;
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            pend_z_q       <= pend_z_d;
            MemInstruction <= mem_instr_d;
            MemData        <= mem_data_d;
            issue_valid    <= issue_valid_d;
            illegal        <= illegal_d;
        end
    end

`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= 8'd0;
        end else if (illegal_hit && (illegal_cnt != 8'hFF)) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end
`else
    logic unused_hit;
    assign unused_hit = illegal_hit;
`endif

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        flush;
    logic [2:0]  SelX, SelY, SelZ;
    logic [1:0]  MemInstruction;
    logic [31:0] MemData;
    logic        issue_valid;
    logic        illegal;
`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
    logic [7:0]  illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    int          m_sx, m_sy, m_sz, m_mi, m_iv, m_ill, m_cnt;
    logic [31:0] m_md;
    int          m_pend, p_sx, p_sy, p_sz;

    instr_decode dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .stall          (stall),
        .flush          (flush),
        .SelX           (SelX),
        .SelY           (SelY),
        .SelZ           (SelZ),
        .MemInstruction (MemInstruction),
        .MemData        (MemData),
        .issue_valid    (issue_valid),
`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
        .illegal_cnt    (illegal_cnt),
`endif
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_sx = 0; m_sy = 0; m_sz = 0; m_mi = 0; m_md = 0; m_iv = 0;
        m_ill = 0; m_cnt = 0; m_pend = 0; p_sx = 0; p_sy = 0; p_sz = 0;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic void model_edge(input logic v, input logic [31:0] w,
                                       input logic s, input logic f);
        int op;
        op = int'(w >> 28);
        if (f) begin
            m_pend = 0; m_iv = 0; m_mi = 0;
        end else if (s) begin
            // everything held
        end else if (!v) begin
            m_iv = 0; m_mi = 0;
        end else if (m_pend != 0) begin
            m_pend = 0;
            m_sx = p_sx; m_sy = p_sy; m_sz = p_sz;
            m_md = w; m_mi = 3; m_iv = 1;
        end else if (op == 4) begin
            m_pend = 1;
            p_sz = int'((w >> 25) & 7); p_sx = int'((w >> 22) & 7); p_sy = int'((w >> 19) & 7);
            m_iv = 0; m_mi = 0;
        end else begin
            m_sz = int'((w >> 25) & 7); m_sx = int'((w >> 22) & 7); m_sy = int'((w >> 19) & 7);
            m_iv = 1;
            if (op <= 2) m_mi = op;
            else if (op == 3) begin
                m_mi = 3;
                m_md = w % (1 << 19);
            end else begin
                m_mi = 0; m_ill = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".SelX"}, 32'(SelX), 32'(m_sx));
        chk({tag, ".SelY"}, 32'(SelY), 32'(m_sy));
        chk({tag, ".SelZ"}, 32'(SelZ), 32'(m_sz));
        chk({tag, ".MemInstruction"}, 32'(MemInstruction), 32'(m_mi));
        chk({tag, ".MemData"}, MemData, m_md);
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(m_iv));
        chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
        chk({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic s, input logic f);
        @(negedge clk);
        instr_valid = v; instr = w; stall = s; flush = f;
        #1 chk({tag, ".instr_ready"}, 32'(instr_ready), 32'(!s));
        @(posedge clk);
        model_edge(v, w, s, f);
        #1 check_all(tag);
    endtask

    function automatic logic [31:0] rand_word();
        int op;
        op = int'($urandom_range(0, 6));
        if (op == 6) op = int'($urandom_range(5, 15));
        return (32'(op) << 28) | ($urandom & 32'h0FFF_FFFF);
    endfunction

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #2 check_all("reset");
        chk("reset.instr_ready", 32'(instr_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        step("idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // LDI short then idle
        step("ldis", 1'b1, 32'h3200_0037, 1'b0, 1'b0);
        chk("ldis.mi_const", 32'(MemInstruction), 32'd3);
        chk("ldis.md_const", MemData, 32'd55);
        chk("ldis.selz_const", 32'(SelZ), 32'd1);
        step("ldis_idle", 1'b0, 32'h0, 1'b0, 1'b0);

        // LDI long with a two-cycle gap
        step("ldil_w1", 1'b1, 32'h4400_0000, 1'b0, 1'b0);
        step("ldil_gap1", 1'b0, 32'h0, 1'b0, 1'b0);
        step("ldil_gap2", 1'b0, 32'h0, 1'b0, 1'b0);
        step("ldil_imm", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("ldil.md_const", MemData, 32'hDEAD_BEEF);
        chk("ldil.selz_const", 32'(SelZ), 32'd2);
        chk("ldil.mi_const", 32'(MemInstruction), 32'd3);

        // Back-to-back OPs
        step("op1", 1'b1, 32'h1050_0000, 1'b0, 1'b0);
        chk("op1.selx_const", 32'(SelX), 32'd1);
        chk("op1.sely_const", 32'(SelY), 32'd2);
        step("op2", 1'b1, 32'h1018_0000, 1'b0, 1'b0);
        chk("op2.sely_const", 32'(SelY), 32'd3);
        chk("op2.iv_const", 32'(issue_valid), 32'd1);

        // Stall three cycles while an issue is on the outputs
        step("st0", 1'b1, 32'h2123_4567, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h3000_0099, 1'b1, 1'b0);
        chk("stall.iv_const", 32'(issue_valid), 32'd1);
        chk("stall.mi_const", 32'(MemInstruction), 32'd2);
        step("unstall", 1'b0, 32'h0, 1'b0, 1'b0);

        // Flush discards pending LDI long (flush beats a valid word and a stall)
        step("fl_w1", 1'b1, 32'h4400_0000, 1'b0, 1'b0);
        step("fl_flush", 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        step("fl_next", 1'b1, 32'h3000_0005, 1'b0, 1'b0);
        chk("fl.md_const", MemData, 32'd5);
        chk("fl.mi_const", 32'(MemInstruction), 32'd3);

        // Illegal opcode is sticky across legal traffic
        step("ill", 1'b1, 32'hF000_0000, 1'b0, 1'b0);
        chk("ill.flag_const", 32'(illegal), 32'd1);
        chk("ill.mi_const", 32'(MemInstruction), 32'd0);
        for (int i = 0; i < 10; i++)
            step("ill_keep", 1'b1, (32'(i % 4) << 28) | ($urandom & 32'h0FFF_FFFF), 1'b0, 1'b0);
        step("ill_keep_end", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("ill.sticky_const", 32'(illegal), 32'd1);

        // Reset in the middle of LDI long
        step("mr_w1", 1'b1, 32'h4E00_0000, 1'b0, 1'b0);
        @(negedge clk);
        instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("midreset");
        chk("midreset.instr_ready", 32'(instr_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        step("mr_next", 1'b1, 32'h3000_0005, 1'b0, 1'b0);
        chk("mr.md_const", MemData, 32'd5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic v, s, f;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 9) == 0);
            step("rand", v, rand_word(), s, f);
        end

`ifdef INSTR_DECODE_ILLEGAL_CNT_EN
        for (int i = 0; i < 300; i++)
            step("cnt", 1'b1, 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF), 1'b0, 1'b0);
        chk("cnt.sat_const", 32'(illegal_cnt), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode and issue stage sitting directly upstream of `GPReg`. Accepts 32-bit instruction words from program memory over a valid/ready handshake, splits them into `SelX`/`SelY`/`SelZ`/`MemInstruction`/`MemData`, and drives those register-file controls from registered outputs. Supports a two-word "load immediate long" form whose second word is the 32-bit immediate, plus downstream stall and flush.

## Interface
- `DATA_W`, 32: instruction and `MemData` width.
- `IMM_W`, 19: short-immediate field width, bits [18:0].

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `instr`  in  32  instruction or immediate word.
- `instr_valid`  in  1  `instr` valid this cycle.
- `instr_ready`  out  1  stage can accept a word; combinational, equals `!stall`.
- `stall`  in  1  downstream cannot take a new issue; registered outputs hold.
- `flush`  in  1  drop in-flight work; synchronous.
- `SelX`, `SelY`, `SelZ`  out  3 each  register selects for `GPReg`.
- `MemInstruction`  out  2  `GPReg` command: 00 NOP, 01 read/op, 10 store, 11 write `MemData` to `SelZ`.
- `MemData`  out  32  immediate data.
- `issue_valid`  out  1  high for each cycle that outputs carry a new instruction.
- `illegal`  out  1  sticky illegal-opcode flag.

## Operation
- Word format: [31:28] opcode, [27:25] SelZ, [24:22] SelX, [21:19] SelY, [18:0] imm.
- Opcodes: 0x0 NOP→00. 0x1 OP→01. 0x2 STORE→10. 0x3 LDI short→11, `MemData` = zero-extended imm. 0x4 LDI long→11, `MemData` = next accepted word. 0x5–0xF illegal.
- Illegal opcode: issued as NOP (`MemInstruction`=00, `issue_valid`=1), `illegal` set; cleared only by `rst`.
- FSM states:
  - DECODE: accepts and decodes a word. Opcode 0x4 latches selects and moves to WAIT_IMM without issuing.
  - WAIT_IMM: the next accepted word is the raw immediate and is never decoded. On acceptance, issues LDI long and returns to DECODE.
- Transfer occurs on `instr_valid && instr_ready`.
- Cycles with no transfer: `issue_valid`=0 and `MemInstruction` forced to 00. Selects and `MemData` hold their last values.
- `stall`=1:
  - `instr_ready`=0.
  - All outputs, including `issue_valid`, hold their current values.
  - FSM holds its state.
- `flush`=1 takes priority over `stall` and transfers:
  - FSM returns to DECODE.
  - Pending LDI long is discarded.
  - Next cycle: `issue_valid`=0, `MemInstruction`=00.
  - `illegal` is unaffected.

## Timing
- Reset values: `SelX`/`SelY`/`SelZ`=0, `MemInstruction`=00, `MemData`=0, `issue_valid`=0, `illegal`=0, FSM=DECODE. `instr_ready` follows `stall` during and after reset.
- Single-word instruction accepted at edge N: outputs and `issue_valid` are valid after edge N, i.e. during cycle N+1. Latency is 1 cycle.
- LDI long: first word at edge N, immediate at edge M>N. Issue is valid during cycle M+1. Gaps between the two words are legal; the FSM waits in WAIT_IMM indefinitely.
- Throughput: one single-word instruction per cycle with `instr_valid` held high and no stall.
- `rst` asserted mid-LDI long: the partial instruction is lost, all outputs go to reset values immediately, and the FSM is in DECODE after release.
- `flush` and a valid word in the same cycle: the word is dropped and not counted as accepted.
- `stall` deasserted: the next edge may accept a word. Held outputs are replaced only when a new issue occurs.

## Configuration
- `INSTR_DECODE_ILLEGAL_CNT_EN` defined:
  - Adds output `illegal_cnt` [7:0].
  - Counts illegal opcodes issued, saturating at 255.
  - Reset to 0 by `rst` only.
  - Increments in the same cycle `illegal` rises/re-asserts.
- Macro undefined: the port and counter are absent; `illegal` behaves identically.

## Test plan
- Reset then idle: `rst` pulse, no valid → all outputs 0, `issue_valid`=0, `instr_ready`=1.
- LDI short: word 0x3200_0037 (SelZ=1, imm=55) → next cycle `MemInstruction`=11, `SelZ`=1, `MemData`=55, `issue_valid`=1. Following idle cycle: `MemInstruction`=00, `issue_valid`=0.
- LDI long with gap: 0x4400_0000, two idle cycles, then 0xDEAD_BEEF → no issue until one cycle after the immediate; then `SelZ`=2, `MemData`=0xDEADBEEF, `MemInstruction`=11.
- OP back-to-back: 0x1050_0000 then 0x1018_0000 on consecutive cycles → issues on consecutive cycles. First issue `SelX`=1, `SelY`=2, `MemInstruction`=01; second `SelX`=0, `SelY`=3.
- Stall and flush: stall for 3 cycles during an issue → outputs frozen and `instr_ready`=0. Separately, 0x4… then `flush` → returns to DECODE; the next word 0x3000_0005 decodes as LDI short (`MemData`=5), not as an immediate.
- Illegal opcode: word 0xF000_0000 → NOP issued, `illegal`=1 and remains 1 through 10 further legal instructions. With `INSTR_DECODE_ILLEGAL_CNT_EN`, 300 illegal words → `illegal_cnt`=255.
